// File: rtl/data_mem_unit.sv
// Byte-addressable RV32 data memory: lane-enabled stores on the clock
// edge, combinational sign/zero-extended loads, per-access fault flags.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), async active-low reset
//   mem_read_i         load request this cycle
//   mem_write_i        store request this cycle
//   funct3_i           RV32 load/store funct3 (size + signedness)
//   addr_i             byte address from the ALU
//   wdata_i            store data (rs2)
//   rdata_o            extended load data, combinational
//   misaligned_o       current access misaligned, combinational
//   out_of_range_o     current word index >= DEPTH_WORDS, combinational
//   fault_sticky_o     set by any faulting access, cleared only by reset
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              misaligned_o,
    output logic              out_of_range_o,
    output logic              fault_sticky_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] LP_DEPTH = (ADDR_W-2)'(DEPTH_WORDS);

    logic              w_active;
    logic [ADDR_W-3:0] w_word_idx;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_unsigned;
    logic              w_illegal;
    logic              w_fault;
    logic              w_we;
    logic [3:0]        w_be;
    logic [31:0]       w_mask;
    logic [31:0]       w_wdata_sh;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_new_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_mem [DEPTH_WORDS];
    logic              r_sticky;

    assign w_active   = mem_read_i | mem_write_i;
    assign w_word_idx = addr_i[ADDR_W-1:2];
    assign w_idx      = addr_i[IDX_W+1:2];
    assign w_lane     = addr_i[1:0];

    assign w_is_byte  = (funct3_i == 3'b000) | (funct3_i == 3'b100);
    assign w_is_half  = (funct3_i == 3'b001) | (funct3_i == 3'b101);
    assign w_is_word  = (funct3_i == 3'b010);
    assign w_unsigned = funct3_i[2];
    // Unsigned variants exist only for loads.
    assign w_illegal  = ~(w_is_byte | w_is_half | w_is_word)
                      | (w_unsigned & mem_write_i);

    assign misaligned_o   = w_active
                          & ((w_is_half & addr_i[0])
                          |  (w_is_word & (w_lane != 2'b00)));
    assign out_of_range_o = w_active & (w_word_idx >= LP_DEPTH);

    assign w_fault = misaligned_o | out_of_range_o
                   | (w_active & w_illegal)
                   | (mem_read_i & mem_write_i);

    assign w_we = mem_write_i & ~w_fault;

    always_comb begin
        w_be = 4'b0000;
        if (w_is_byte) begin
            w_be = 4'b0001 << w_lane;
        end else if (w_is_half) begin
            w_be = 4'b0011 << w_lane;
        end else if (w_is_word) begin
            w_be = 4'b1111;
        end
    end

    assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}},
                     {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wdata_sh = wdata_i << {w_lane, 3'b000};

    // Read-modify-write merge of the addressed word, so each storage
    // word only needs a single full-width register update.
    assign w_rd_word  = w_mem[w_idx];
    assign w_new_word = (w_rd_word & ~w_mask) | (w_wdata_sh & w_mask);

    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
        logic [31:0] r_word;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_word <= '0;
            end else if (w_we && (w_idx == IDX_W'(g))) begin
                r_word <= w_new_word;
            end
        end

        assign w_mem[g] = r_word;
    end

    assign w_byte = w_rd_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        rdata_o = '0;
        if (mem_read_i && !w_fault) begin
            if (w_is_byte) begin
                rdata_o = w_unsigned ? {24'h0, w_byte}
                                     : {{24{w_byte[7]}}, w_byte};
            end else if (w_is_half) begin
                rdata_o = w_unsigned ? {16'h0, w_half}
                                     : {{16{w_half[15]}}, w_half};
            end else begin
                rdata_o = w_rd_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky <= 1'b0;
        end else if (w_fault) begin
            r_sticky <= 1'b1;
        end
    end

    assign fault_sticky_o = r_sticky;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed testbench for data_mem_unit.
// Drives accesses on the falling edge, checks outputs 1ns later.
module tb_data_mem_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        out_of_range_o;
    logic        fault_sticky_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_mem_unit #(
        .DEPTH_WORDS(1024),
        .ADDR_W     (32)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .misaligned_o  (misaligned_o),
        .out_of_range_o(out_of_range_o),
        .fault_sticky_o(fault_sticky_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    // Apply an access at the current (falling-edge) time and settle.
    task automatic drive(input logic        rd,
                         input logic        wr,
                         input logic [2:0]  f3,
                         input logic [31:0] a,
                         input logic [31:0] wd);
        mem_read_i  = rd;
        mem_write_i = wr;
        funct3_i    = f3;
        addr_i      = a;
        wdata_i     = wd;
        #1;
    endtask

    task automatic idle_step();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        @(negedge clk_i);
    endtask

    task automatic store_step(input logic [2:0]  f3,
                              input logic [31:0] a,
                              input logic [31:0] wd);
        drive(1'b0, 1'b1, f3, a, wd);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, F_W, 32'h0, 32'h0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        funct3_i    = F_W;
        addr_i      = '0;
        wdata_i     = '0;
        @(negedge clk_i);
        do_reset();

        // Reset state
        drive(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        chk("rst_lw0", rdata_o, 32'h0);
        chk("rst_sticky", {31'h0, fault_sticky_o}, 32'h0);
        drive(1'b1, 1'b0, F_W, 32'h4, 32'h0);
        chk("rst_lw4", rdata_o, 32'h0);
        drive(1'b1, 1'b0, F_W, 32'hFFC, 32'h0);
        chk("rst_lwffc", rdata_o, 32'h0);
        chk("ffc_in_range", {31'h0, out_of_range_o}, 32'h0);

        // Word round trip and load extensions
        store_step(F_W, 32'h10, 32'hDEADBEEF);
        drive(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        chk("lw10", rdata_o, 32'hDEADBEEF);
        drive(1'b1, 1'b0, F_B, 32'h10, 32'h0);
        chk("lb10", rdata_o, 32'hFFFFFFEF);
        drive(1'b1, 1'b0, F_BU, 32'h13, 32'h0);
        chk("lbu13", rdata_o, 32'h000000DE);
        drive(1'b1, 1'b0, F_H, 32'h12, 32'h0);
        chk("lh12", rdata_o, 32'hFFFFDEAD);
        drive(1'b1, 1'b0, F_HU, 32'h10, 32'h0);
        chk("lhu10", rdata_o, 32'h0000BEEF);
        drive(1'b1, 1'b0, F_B, 32'h11, 32'h0);
        chk("lb11", rdata_o, 32'hFFFFFFBE);

        // Partial stores
        store_step(F_W, 32'h20, 32'h00000000);
        store_step(F_B, 32'h21, 32'hFFFFFFAA);
        store_step(F_H, 32'h22, 32'hFFFF1234);
        drive(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        chk("lw20_part", rdata_o, 32'h1234AA00);
        chk("no_fault_yet", {31'h0, fault_sticky_o}, 32'h0);

        // Misaligned store
        drive(1'b0, 1'b1, F_W, 32'h22, 32'h11111111);
        chk("sw22_mis", {31'h0, misaligned_o}, 32'h1);
        chk("sw22_sticky_pre", {31'h0, fault_sticky_o}, 32'h0);
        @(negedge clk_i);
        drive(1'b1, 1'b0, F_W, 32'h20, 32'h0);
        chk("sw22_sticky", {31'h0, fault_sticky_o}, 32'h1);
        chk("lw20_kept", rdata_o, 32'h1234AA00);
        drive(1'b1, 1'b0, F_H, 32'h23, 32'h0);
        chk("lh23_data", rdata_o, 32'h0);
        chk("lh23_mis", {31'h0, misaligned_o}, 32'h1);
        drive(1'b1, 1'b0, F_B, 32'h23, 32'h0);
        chk("lb23_not_mis", {31'h0, misaligned_o}, 32'h0);

        // Out of range
        drive(1'b1, 1'b0, F_W, 32'h1000, 32'h0);
        chk("lw1000_oor", {31'h0, out_of_range_o}, 32'h1);
        chk("lw1000_data", rdata_o, 32'h0);
        drive(1'b0, 1'b0, F_W, 32'h1000, 32'h0);
        chk("idle_no_oor", {31'h0, out_of_range_o}, 32'h0);
        store_step(F_W, 32'h1000, 32'hCAFECAFE);
        drive(1'b1, 1'b0, F_W, 32'h0, 32'h0);
        chk("no_alias", rdata_o, 32'h0);

        // Reset pending store
        drive(1'b0, 1'b1, F_B, 32'h40, 32'h00000055);
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b1, 1'b0, F_W, 32'h40, 32'h0);
        chk("rst_mid_word", rdata_o, 32'h0);
        chk("rst_mid_sticky", {31'h0, fault_sticky_o}, 32'h0);
        drive(1'b1, 1'b0, F_W, 32'h10, 32'h0);
        chk("rst_clr_10", rdata_o, 32'h0);

        // Illegal store funct3
        store_step(F_BU, 32'h30, 32'hFFFFFFFF);
        drive(1'b1, 1'b0, F_W, 32'h30, 32'h0);
        chk("sbu_nowrite", rdata_o, 32'h0);
        chk("sbu_sticky", {31'h0, fault_sticky_o}, 32'h1);

        // Simultaneous read and write
        do_reset();
        drive(1'b1, 1'b1, F_W, 32'h30, 32'h00000005);
        chk("rdwr_data", rdata_o, 32'h0);
        @(negedge clk_i);
        drive(1'b1, 1'b0, F_W, 32'h30, 32'h0);
        chk("rdwr_nowrite", rdata_o, 32'h0);
        chk("rdwr_sticky", {31'h0, fault_sticky_o}, 32'h1);
        idle_step();
        chk("sticky_holds", {31'h0, fault_sticky_o}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Byte-addressable data memory stage directly downstream of the ALU in the single-cycle RV32 datapath.
- The ALU result (c_num_o) drives addr_i as the effective address for loads and stores.
- Stores commit on the clock edge with byte/half/word lane enables. Loads return combinationally, sign- or zero-extended for writeback.
- Alignment and range faults are flagged per access and accumulated in a sticky status register.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
ADDR_W, 32, width of addr_i

Ports:
clk_i  input  1  clock, rising edge active
rst_ni  input  1  asynchronous active-low reset
mem_read_i  input  1  load request this cycle
mem_write_i  input  1  store request this cycle
funct3_i  input  3  RV32 load/store funct3 (access size and signedness)
addr_i  input  ADDR_W  byte address (from ALU c_num_o)
wdata_i  input  32  store data (rs2); low bytes are used for SB/SH
rdata_o  output  32  extended load data, combinational
misaligned_o  output  1  current access is misaligned, combinational
out_of_range_o  output  1  current access word index >= DEPTH_WORDS, combinational
fault_sticky_o  output  1  registered; set by any faulting access

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - Every memory word clears to 0 and fault_sticky_o clears to 0.
  - Reset takes priority over a store in the same cycle; nothing is written.
- Access:
  - active = mem_read_i | mem_write_i.
  - word index = addr_i[ADDR_W-1:2]; lane = addr_i[1:0].
- Legal funct3:
  - 000: LB/SB.
  - 001: LH/SH.
  - 010: LW/SW.
  - 100: LBU (load only).
  - 101: LHU (load only).
  - Any other code, or 100/101 with mem_write_i, is illegal.
- misaligned_o = active & ((half access & addr_i[0]) | (word access & addr_i[1:0]!=0)). Byte accesses are never misaligned.
- out_of_range_o = active & (word index >= DEPTH_WORDS).
- fault = misaligned_o | out_of_range_o | (active & illegal funct3) | (mem_read_i & mem_write_i).
- Store (rising edge, mem_write_i & !fault & rst_ni):
  - SB writes lane addr[1:0] with wdata_i[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata_i[15:0], little-endian.
  - SW writes all four lanes with wdata_i.
  - Unselected lanes are unchanged.
- Load (combinational, mem_read_i & !fault):
  - LB/LH sign-extend the selected lane(s).
  - LBU/LHU zero-extend.
  - LW returns the full word.
- rdata_o = 0 whenever mem_read_i=0 or fault=1.
- Read and store to the same word in the same cycle: cannot occur legally (both requests together are a fault). Combinational reads always show pre-edge array contents; a store becomes visible in the cycle after its edge.
- fault_sticky_o:
  - Set at the rising edge when fault=1.
  - Holds until reset; no other clear path.
  - Latency 1 cycle from the faulting access.
- Address wrap: none. Addresses above the range fault; they are not aliased.

Test Plan:
- Reset then read: rst_ni low 2 cycles, release; LW at 0x0, 0x4, 0xFFC -> rdata_o=0x00000000, fault_sticky_o=0.
- Word round trip: SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> 0xDEADBEEF. LB @0x10 -> 0xFFFFFFEF. LBU @0x13 -> 0x000000DE. LH @0x12 -> 0xFFFFDEAD. LHU @0x10 -> 0x0000BEEF.
- Partial stores: SW 0x00000000 @0x20, SB 0xAA @0x21, SH 0x1234 @0x22 -> LW @0x20 = 0x1234AA00.
- Misalignment: SW 0x11111111 @0x22 -> misaligned_o=1 same cycle, word 0x20 unchanged, fault_sticky_o=1 next cycle. LH @0x23 -> rdata_o=0, misaligned_o=1.
- Range/illegal: LW @0x1000 (DEPTH_WORDS=1024) -> out_of_range_o=1, rdata_o=0. Store with funct3=100 -> no write, sticky set. mem_read_i=mem_write_i=1 -> no write, rdata_o=0.
- Reset mid-operation: store 0x55 pending with rst_ni dropped before the edge -> word reads 0 after release, sticky 0.
